// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - arbitration mode constants and broadcast entry layout helpers
package cdb_arbiter_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // A broadcast entry is packed as {tag, data}, tag in the upper bits.
  function automatic int bcast_entry_width(input int tag_w, input int data_w);
    return tag_w + data_w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - per-unit result queue with wrap-bit pointers and synchronous flush
module result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty = (r_wptr == r_rptr);
  assign w_wr  = push && !full && !flush;
  assign w_rd  = pop && !empty && !flush;
  assign dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - buffers functional-unit results and broadcasts one per cycle on the CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 4,
  parameter int NUM_FU      = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_FU-1:0]               fu_valid,
  input  logic [NUM_FU*TAG_WIDTH-1:0]     fu_tag,
  input  logic [NUM_FU*DATA_WIDTH-1:0]    fu_data,
  output logic [NUM_FU-1:0]               queueFull,
  output logic                            queueEmpty,
  input  logic                            allowBroadcast,
  output logic                            broadcastDataAvailable,
  output logic [TAG_WIDTH-1:0]            broadcastDestinationTag,
  output logic [DATA_WIDTH-1:0]           broadcastDestinationData
);

  localparam int EW = bcast_entry_width(TAG_WIDTH, DATA_WIDTH);
  localparam int IW = idx_width(NUM_FU);

  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_pop;
  logic [NUM_FU-1:0] w_full;
  logic [NUM_FU-1:0] w_empty;
  logic [EW-1:0]     w_dout [NUM_FU];

  logic              w_load;
  logic              w_grant_vld;
  logic [IW-1:0]     w_grant_idx;
  logic [IW-1:0]     w_scan_idx;

  logic              r_bv;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IW-1:0]     r_last_grant;

  assign w_load = !r_bv || allowBroadcast;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    assign w_push[g] = fu_valid[g] && !flush;
    assign w_pop[g]  = w_load && w_grant_vld && (w_grant_idx == IW'(g)) && !flush;

    result_fifo #(
      .WIDTH (EW),
      .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (w_push[g]),
      .din   ({fu_tag[g*TAG_WIDTH +: TAG_WIDTH], fu_data[g*DATA_WIDTH +: DATA_WIDTH]}),
      .pop   (w_pop[g]),
      .dout  (w_dout[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
  end

  // Both scans run from the far end so the last hit is the highest-priority requester.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan_idx  = '0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = NUM_FU - 1; i >= 0; i--) begin
        w_scan_idx = IW'(i);
        if (!w_empty[w_scan_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_scan_idx;
        end
      end
    end else begin
      for (int k = NUM_FU; k >= 1; k--) begin
        w_scan_idx = IW'((int'(r_last_grant) + k) % NUM_FU);
        if (!w_empty[w_scan_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_scan_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bv         <= 1'b0;
      r_tag        <= '0;
      r_data       <= '0;
      r_last_grant <= '0;
    end else if (flush) begin
      r_bv         <= 1'b0;
      r_last_grant <= '0;
    end else if (w_load) begin
      r_bv <= w_grant_vld;
      if (w_grant_vld) begin
        {r_tag, r_data} <= w_dout[w_grant_idx];
        r_last_grant    <= w_grant_idx;
      end
    end
  end

  assign queueFull                = w_full;
  assign queueEmpty               = (&w_empty) && !r_bv;
  assign broadcastDataAvailable   = r_bv;
  assign broadcastDestinationTag  = r_tag;
  assign broadcastDestinationData = r_data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter in round-robin and fixed-priority modes
module tb_cdb_arbiter;

  localparam int DEPTH = 4;

  typedef logic [35:0] ent_t;

  typedef struct {
    int          dut;
    logic [3:0]  fv;
    logic [15:0] tags;
    logic [31:0] data;
    logic        allow;
    logic        flush;
    logic        e_bv;
    logic [3:0]  e_tag;
    logic [31:0] e_data;
    logic [3:0]  e_qf;
    logic        e_qe;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   fv [2];
  logic [15:0]  ft [2];
  logic [127:0] fd [2];
  logic         allow [2];
  logic         fl [2];
  logic [3:0]   qf [2];
  logic         qe [2];
  logic         bv [2];
  logic [3:0]   bt [2];
  logic [31:0]  bd [2];

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        mq [2][4][$];
  logic        mbv [2];
  logic [3:0]  mtag [2];
  logic [31:0] mdat [2];
  int          mlast [2];

  vec_t tbl [$];

  always #5 clk = ~clk;

  cdb_arbiter #(
    .DATA_WIDTH(32), .TAG_WIDTH(4), .NUM_FU(4), .QUEUE_DEPTH(4), .ARB_MODE(0)
  ) dut_rr (
    .clk(clk), .rst(rst), .flush(fl[0]), .fu_valid(fv[0]), .fu_tag(ft[0]), .fu_data(fd[0]),
    .queueFull(qf[0]), .queueEmpty(qe[0]), .allowBroadcast(allow[0]),
    .broadcastDataAvailable(bv[0]), .broadcastDestinationTag(bt[0]),
    .broadcastDestinationData(bd[0])
  );

  cdb_arbiter #(
    .DATA_WIDTH(32), .TAG_WIDTH(4), .NUM_FU(4), .QUEUE_DEPTH(4), .ARB_MODE(1)
  ) dut_fp (
    .clk(clk), .rst(rst), .flush(fl[1]), .fu_valid(fv[1]), .fu_tag(ft[1]), .fu_data(fd[1]),
    .queueFull(qf[1]), .queueEmpty(qe[1]), .allowBroadcast(allow[1]),
    .broadcastDataAvailable(bv[1]), .broadcastDestinationTag(bt[1]),
    .broadcastDestinationData(bd[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int dut, input logic [3:0] fvv, input logic [15:0] tags,
                              input logic [31:0] data, input logic al, input logic fls,
                              input logic e_bv, input logic [3:0] e_tag, input logic [31:0] e_data,
                              input logic [3:0] e_qf, input logic e_qe);
    vec_t v;
    v.dut = dut; v.fv = fvv; v.tags = tags; v.data = data; v.allow = al; v.flush = fls;
    v.e_bv = e_bv; v.e_tag = e_tag; v.e_data = e_data; v.e_qf = e_qf; v.e_qe = e_qe;
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) mq[d][i].delete();
      mbv[d] = 1'b0; mtag[d] = '0; mdat[d] = '0; mlast[d] = 0;
    end
  endtask

  task automatic model_edge(input int d);
    bit   pre_full [4];
    int   w;
    int   j;
    ent_t e;
    if (fl[d]) begin
      for (int i = 0; i < 4; i++) mq[d][i].delete();
      mbv[d] = 1'b0;
      mlast[d] = 0;
      return;
    end
    for (int i = 0; i < 4; i++) pre_full[i] = (mq[d][i].size() == DEPTH);
    if (!mbv[d] || allow[d]) begin
      w = -1;
      if (d == 1) begin
        for (int i = 0; i < 4 && w < 0; i++)
          if (mq[d][i].size() != 0) w = i;
      end else begin
        for (int k = 1; k <= 4 && w < 0; k++) begin
          j = (mlast[d] + k) % 4;
          if (mq[d][j].size() != 0) w = j;
        end
      end
      if (w >= 0) begin
        e = mq[d][w].pop_front();
        mbv[d] = 1'b1; mtag[d] = e[35:32]; mdat[d] = e[31:0]; mlast[d] = w;
      end else begin
        mbv[d] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++)
      if (fv[d][i] && !pre_full[i]) mq[d][i].push_back({ft[d][i*4 +: 4], fd[d][i*32 +: 32]});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else for (int d = 0; d < 2; d++) model_edge(d);
    #1;
  endtask

  task automatic idle(input int d);
    fv[d] = '0; ft[d] = '0; fd[d] = '0; allow[d] = 1'b1; fl[d] = 1'b0;
  endtask

  task automatic chk_reset(input string nm, input int d);
    chk({nm, "_bv"}, 64'(bv[d]), 64'd0);
    chk({nm, "_tag"}, 64'(bt[d]), 64'd0);
    chk({nm, "_data"}, 64'(bd[d]), 64'd0);
    chk({nm, "_qf"}, 64'(qf[d]), 64'd0);
    chk({nm, "_qe"}, 64'(qe[d]), 64'd1);
  endtask

  task automatic cmp_model(input int d, input int cyc);
    logic [3:0] e_qf;
    logic       e_qe;
    e_qe = !mbv[d];
    for (int i = 0; i < 4; i++) begin
      e_qf[i] = (mq[d][i].size() == DEPTH);
      if (mq[d][i].size() != 0) e_qe = 1'b0;
    end
    chk($sformatf("rnd%0d_bv@%0d", d, cyc), 64'(bv[d]), 64'(mbv[d]));
    chk($sformatf("rnd%0d_qf@%0d", d, cyc), 64'(qf[d]), 64'(e_qf));
    chk($sformatf("rnd%0d_qe@%0d", d, cyc), 64'(qe[d]), 64'(e_qe));
    if (mbv[d]) begin
      chk($sformatf("rnd%0d_tag@%0d", d, cyc), 64'(bt[d]), 64'(mtag[d]));
      chk($sformatf("rnd%0d_data@%0d", d, cyc), 64'(bd[d]), 64'(mdat[d]));
    end
  endtask

  initial begin
    vec_t v;

    // single result, then flush to return lastGrant to 0
    tbl.push_back(mk(0, 4'b0100, 16'h0500, 32'hDEADBEEF, 1, 0, 0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 5, 32'hDEADBEEF, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 0, 0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 1, 0, 0, 0, 4'h0, 1));
    // round-robin from lastGrant=0: order is unit 1,2,3,0
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 32'h11110000, 1, 0, 0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 2, 32'h11110000, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 3, 32'h11110000, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 4, 32'h11110000, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 1, 32'h11110000, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 0, 0, 0, 4'h0, 1));
    // lastGrant=1 after unit 1 wins alone: order is unit 2,3,0,1
    tbl.push_back(mk(0, 4'b0010, 16'h0090, 32'h22220000, 1, 0, 0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 32'h33330000, 1, 0, 1, 9, 32'h22220000, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 3, 32'h33330000, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 4, 32'h33330000, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 1, 32'h33330000, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 2, 32'h33330000, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 0, 0, 0, 4'h0, 1));
    // back-pressure on unit 1; push 6 is dropped, push 7 collides with a pop on a full queue
    tbl.push_back(mk(0, 4'b0010, 16'h0010, 32'h44440001, 0, 0, 0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0010, 16'h0020, 32'h44440002, 0, 0, 1, 1, 32'h44440001, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0010, 16'h0030, 32'h44440003, 0, 0, 1, 1, 32'h44440001, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0010, 16'h0040, 32'h44440004, 0, 0, 1, 1, 32'h44440001, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0010, 16'h0050, 32'h44440005, 0, 0, 1, 1, 32'h44440001, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0010, 16'h0060, 32'h44440006, 0, 0, 1, 1, 32'h44440001, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0010, 16'h0070, 32'h44440007, 1, 0, 1, 2, 32'h44440002, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 3, 32'h44440003, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 4, 32'h44440004, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 1, 5, 32'h44440005, 4'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 32'h0, 1, 0, 0, 0, 0, 4'h0, 1));
    // fixed priority: units 0 and 3 push every cycle, unit 3 starves and fills
    tbl.push_back(mk(1, 4'b1001, 16'h8001, 32'h55550000, 1, 0, 0, 0, 0, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1001, 16'h8001, 32'h55550000, 1, 0, 1, 1, 32'h55550000, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1001, 16'h8001, 32'h55550000, 1, 0, 1, 1, 32'h55550000, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1001, 16'h8001, 32'h55550000, 1, 0, 1, 1, 32'h55550000, 4'b1000, 0));
    tbl.push_back(mk(1, 4'b1001, 16'h8001, 32'h55550000, 1, 0, 1, 1, 32'h55550000, 4'b1000, 0));
    tbl.push_back(mk(1, 4'b0000, 16'h0000, 32'h0, 1, 1, 0, 0, 0, 4'h0, 1));

    rst = 1'b1;
    idle(0);
    idle(1);
    model_reset();
    #1;
    chk_reset("rst0_rr", 0);
    chk_reset("rst0_fp", 1);
    step();
    step();
    rst = 1'b0;

    for (int n = 0; n < tbl.size(); n++) begin
      v = tbl[n];
      idle(0);
      idle(1);
      fv[v.dut] = v.fv; ft[v.dut] = v.tags; fd[v.dut] = {4{v.data}};
      allow[v.dut] = v.allow; fl[v.dut] = v.flush;
      step();
      chk($sformatf("tbl%0d_bv", n), 64'(bv[v.dut]), 64'(v.e_bv));
      chk($sformatf("tbl%0d_qf", n), 64'(qf[v.dut]), 64'(v.e_qf));
      chk($sformatf("tbl%0d_qe", n), 64'(qe[v.dut]), 64'(v.e_qe));
      if (v.e_bv) begin
        chk($sformatf("tbl%0d_tag", n), 64'(bt[v.dut]), 64'(v.e_tag));
        chk($sformatf("tbl%0d_data", n), 64'(bd[v.dut]), 64'(v.e_data));
      end
    end

    // six results held (five queued plus the broadcast register), then a one-cycle flush
    idle(0);
    idle(1);
    fv[0] = 4'b1111; ft[0] = 16'h7654; fd[0] = {4{32'h66660000}}; allow[0] = 1'b0;
    step();
    fv[0] = 4'b0011; ft[0] = 16'h00BA;
    step();
    chk("fl6_pre_bv", 64'(bv[0]), 64'd1);
    chk("fl6_pre_qe", 64'(qe[0]), 64'd0);
    fv[0] = 4'b0000; fl[0] = 1'b1;
    step();
    chk("fl6_bv", 64'(bv[0]), 64'd0);
    chk("fl6_qe", 64'(qe[0]), 64'd1);
    chk("fl6_qf", 64'(qf[0]), 64'd0);
    fl[0] = 1'b0;
    step();
    chk("fl6_after_qe", 64'(qe[0]), 64'd1);

    // asynchronous reset in the middle of the clock period
    fv[0] = 4'b1111; fv[1] = 4'b1111; ft[0] = 16'h3A5C; ft[1] = 16'hC5A3;
    fd[0] = {4{32'h77770000}}; fd[1] = {4{32'h88880000}};
    allow[0] = 1'b0; allow[1] = 1'b0;
    step();
    step();
    chk("arst_pre_bv_rr", 64'(bv[0]), 64'd1);
    chk("arst_pre_bv_fp", 64'(bv[1]), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst_rr", 0);
    chk_reset("arst_fp", 1);
    idle(0);
    idle(1);
    step();
    rst = 1'b0;
    model_reset();
    chk_reset("arst_hold_rr", 0);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        allow[d] = ($urandom_range(0, 9) < 7);
        fl[d]    = ($urandom_range(0, 63) == 0);
        ft[d]    = 16'($urandom);
        fd[d]    = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++)
          fv[d][i] = ($urandom_range(0, 1) == 1) &&
                     ((mq[d][i].size() < DEPTH) || ($urandom_range(0, 19) == 0));
      end
      step();
      cmp_model(0, cyc);
      cmp_model(1, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
